// File: rtl/uart_hex_sender_if.sv
// Producer/transmitter-side bundle of the hex sender.
// The master side feeds words and models the byte transmitter;
// the slave side is the hex sender itself.
interface uart_hex_sender_if;
  logic [15:0] din;
  logic        din_valid;
  logic        full;
  logic        overflow;
  logic        busy;
  logic [7:0]  tbus;
  logic        tstart;
  logic        tx_ready;

  modport master (
    output din, din_valid, tx_ready,
    input  full, overflow, busy, tbus, tstart
  );

  modport slave (
    input  din, din_valid, tx_ready,
    output full, overflow, busy, tbus, tstart
  );
endinterface

// File: rtl/uart_hex_sender.sv
// Buffers 16-bit words in a small FIFO and prints each one as four
// uppercase ASCII hex digits plus a separator, one byte per
// transmitter start/ready handshake.
module uart_hex_sender #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int NEWLINE = 1
) (
  input  logic               clk,
  input  logic               rstn,
  uart_hex_sender_if.slave   bus
);

  // Index of the final byte of a word: CR LF ends at 5, a space at 4.
  localparam logic [2:0] LAST_IDX = (NEWLINE != 0) ? 3'd5 : 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [15:0]       word_q, word_d;
  logic [7:0]        tbus_q, tbus_d;
  logic              tstart_q, tstart_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [15:0]       mem_q [DEPTH];

  logic              empty_s;
  logic              full_now_s;
  logic              push_s;
  logic              pop_s;

  // Byte to send for position idx of word w.
  function automatic logic [7:0] hex_char(input logic [15:0] w, input logic [2:0] idx);
    logic [3:0] nib;
    logic [7:0] ch;
    nib = 4'h0;
    ch  = 8'h00;
    case (idx)
      3'd0: nib = w[15:12];
      3'd1: nib = w[11:8];
      3'd2: nib = w[7:4];
      3'd3: nib = w[3:0];
      default: nib = 4'h0;
    endcase
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        if (nib < 4'd10) begin
          ch = 8'h30 + {4'h0, nib};
        end else begin
          ch = 8'h37 + {4'h0, nib};
        end
      end
      3'd4: ch = (NEWLINE != 0) ? 8'h0D : 8'h20;
      3'd5: ch = 8'h0A;
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

  // FIFO bookkeeping: accept a write unless full, a pop on the same edge frees a slot.
  always_comb begin
    empty_s    = (wptr_q == rptr_q);
    full_now_s = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                 (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    pop_s      = (state_q == S_IDLE) && !empty_s;
    push_s     = bus.din_valid && (!full_now_s || pop_s);
    wptr_d     = wptr_q + {{ADDR_W{1'b0}}, push_s};
    rptr_d     = rptr_q + {{ADDR_W{1'b0}}, pop_s};
    full_d     = (wptr_d[ADDR_W] != rptr_d[ADDR_W]) &&
                 (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]);
    overflow_d = bus.din_valid && !push_s;
  end

  // Sequencer: pop a word, then wait for ready / issue each byte in turn.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    tbus_d  = tbus_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          word_d  = mem_q[rptr_q[ADDR_W-1:0]];
          idx_d   = 3'd0;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.tx_ready) begin
          tbus_d  = hex_char(word_q, idx_q);
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
    endcase
    tstart_d = (state_d == S_ISSUE);
    busy_d   = (state_d != S_IDLE) || (wptr_d != rptr_d);
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      word_q     <= 16'h0000;
      tbus_q     <= 8'h00;
      tstart_q   <= 1'b0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      tbus_q     <= tbus_d;
      tstart_q   <= tstart_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= bus.din;
    end
  end

  assign bus.tbus     = tbus_q;
  assign bus.tstart   = tstart_q;
  assign bus.full     = full_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_hex_sender.sv
// Randomised scoreboard bench for uart_hex_sender: one instance with a
// CR LF separator and one with a space separator, each driven by its own
// transmitter model.
module tb_uart_hex_sender;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  uart_hex_sender_if b1 ();
  uart_hex_sender_if b0 ();

  uart_hex_sender #(.DEPTH(4), .ADDR_W(2), .NEWLINE(1)) dut1 (.clk(clk), .rstn(rstn), .bus(b1));
  uart_hex_sender #(.DEPTH(4), .ADDR_W(2), .NEWLINE(0)) dut0 (.clk(clk), .rstn(rstn), .bus(b0));

  always #5 clk = ~clk;

  // cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- transmitter models ----------------
  logic rdy1 = 1'b1, rdy0 = 1'b1;
  logic hold1 = 1'b0, hold0 = 1'b0;
  int   cnt1 = 0, cnt0 = 0;
  int   lat1 = 50, lat0 = 50;

  assign b1.tx_ready = rdy1 & ~hold1;
  assign b0.tx_ready = rdy0 & ~hold0;

  // transmitter 1: busy for lat1 cycles after each start
  always @(posedge clk) begin
    if (b1.tstart) begin
      rdy1 <= 1'b0;
      cnt1 <= lat1;
    end else if (!rdy1) begin
      if (cnt1 <= 1) rdy1 <= 1'b1;
      else cnt1 <= cnt1 - 1;
    end
  end

  // transmitter 0: busy for lat0 cycles after each start
  always @(posedge clk) begin
    if (b0.tstart) begin
      rdy0 <= 1'b0;
      cnt0 <= lat0;
    end else if (!rdy0) begin
      if (cnt0 <= 1) rdy0 <= 1'b1;
      else cnt0 <= cnt0 - 1;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  function automatic logic [7:0] digit(input logic [15:0] w, input int pos);
    int n;
    n = (int'(w) >> (12 - 4 * pos)) % 16;
    if (n < 10) return 8'(48 + n);      // '0'..'9'
    else        return 8'(65 + n - 10); // 'A'..'F'
  endfunction

  task automatic exp1(input logic [15:0] w);
    for (int i = 0; i < 4; i++) q1.push_back(digit(w, i));
    q1.push_back(8'd13);
    q1.push_back(8'd10);
  endtask

  task automatic exp0(input logic [15:0] w);
    for (int i = 0; i < 4; i++) q0.push_back(digit(w, i));
    q0.push_back(8'd32);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int pulses1 = 0, pulses0 = 0;
  int ovf1 = 0, ovf0 = 0;
  int last_ts1 = 0, last_ts0 = 0;

  // pop expected bytes on every start pulse; count overflow pulses
  always @(negedge clk) begin
    if (rstn) begin
      if (b1.tstart) begin
        pulses1++;
        last_ts1 = cyc;
        if (q1.size() == 0) check("unexpected_tstart1", {24'h0, b1.tbus}, 32'hFFFF_FFFF);
        else check("byte1", {24'h0, b1.tbus}, {24'h0, q1.pop_front()});
      end
      if (b0.tstart) begin
        pulses0++;
        last_ts0 = cyc;
        if (q0.size() == 0) check("unexpected_tstart0", {24'h0, b0.tbus}, 32'hFFFF_FFFF);
        else check("byte0", {24'h0, b0.tbus}, {24'h0, q0.pop_front()});
      end
      if (b1.overflow) ovf1++;
      if (b0.overflow) ovf0++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'h0, (q1.size() == 0 && q0.size() == 0)}, 32'h1);
  endtask

  initial begin
    int k, p, n, pushed;
    logic [15:0] w;
    b1.din = 16'h0; b1.din_valid = 1'b0;
    b0.din = 16'h0; b0.din_valid = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;

    // reset state held with an idle, ready transmitter
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rst_tstart", {31'h0, b1.tstart}, 32'h0);
      check("rst_tbus", {24'h0, b1.tbus}, 32'h0);
      check("rst_busy", {31'h0, b1.busy}, 32'h0);
      check("rst_full", {31'h0, b1.full}, 32'h0);
    end

    // CR LF word, latency and busy fall
    p = pulses1;
    b1.din = 16'h1C2F; b1.din_valid = 1'b1; k = cyc; exp1(16'h1C2F);
    tick();
    b1.din_valid = 1'b0;
    n = 0;
    while (pulses1 == p && n < 20) begin tick(); n++; end
    check("latency", last_ts1 - k, 32'd3);
    wait_drain("drain_nl1", 1000);
    check("busy_last_byte", {31'h0, b1.busy}, 32'h1);
    tick();
    check("busy_fall", {31'h0, b1.busy}, 32'h0);
    check("pulses_nl1", pulses1 - p, 32'd6);

    // space-separated word
    p = pulses0;
    b0.din = 16'hA09F; b0.din_valid = 1'b1; exp0(16'hA09F);
    tick();
    b0.din_valid = 1'b0;
    wait_drain("drain_nl0", 1000);
    tick();
    check("busy_fall0", {31'h0, b0.busy}, 32'h0);
    check("pulses_nl0", pulses0 - p, 32'd5);

    // overflow with the transmitter held off
    lat1 = 3; hold1 = 1'b1;
    b1.din = 16'h0000; b1.din_valid = 1'b1; exp1(16'h0000);
    tick();
    b1.din_valid = 1'b0;
    repeat (3) tick();
    for (int i = 1; i <= 5; i++) begin
      b1.din = 16'(i); b1.din_valid = 1'b1;
      if (i < 5) exp1(16'(i));
      tick();
      b1.din_valid = 1'b0;
      check("full_fill", {31'h0, b1.full}, {31'h0, (i >= 4)});
      check("ovf_fill", {31'h0, b1.overflow}, {31'h0, (i == 5)});
    end
    tick();
    check("ovf_one_cycle", {31'h0, b1.overflow}, 32'h0);
    check("ovf_count", ovf1, 32'd1);

    // push on the pop edge while full
    p = pulses1;
    hold1 = 1'b0;
    n = 0;
    while (pulses1 < p + 6 && n < 500) begin tick(); n++; end
    check("first_word_done", pulses1 - p, 32'd6);
    tick();
    b1.din = 16'h00AB; b1.din_valid = 1'b1; exp1(16'h00AB);
    tick();
    b1.din_valid = 1'b0;
    check("simul_no_ovf", {31'h0, b1.overflow}, 32'h0);
    check("simul_full", {31'h0, b1.full}, 32'h1);
    wait_drain("drain_ovf", 2000);
    tick();
    check("ovf_count2", ovf1, 32'd1);

    // reset in the middle of the 3rd byte with two more words queued
    lat1 = 20;
    p = pulses1;
    for (int i = 0; i < 3; i++) begin
      w = 16'h5A00 + 16'(i);
      b1.din = w; b1.din_valid = 1'b1; exp1(w);
      tick();
    end
    b1.din_valid = 1'b0;
    n = 0;
    while (pulses1 < p + 3 && n < 500) begin tick(); n++; end
    check("mid_bytes", pulses1 - p, 32'd3);
    check("mid_tstart_before", {31'h0, b1.tstart}, 32'h1);
    rstn = 1'b0;
    #1;
    check("mid_tstart", {31'h0, b1.tstart}, 32'h0);
    check("mid_tbus", {24'h0, b1.tbus}, 32'h0);
    check("mid_full", {31'h0, b1.full}, 32'h0);
    check("mid_busy", {31'h0, b1.busy}, 32'h0);
    q1.delete();
    repeat (3) tick();
    rstn = 1'b1;
    p = pulses1;
    repeat (100) tick();
    check("mid_no_more", pulses1 - p, 32'd0);
    check("mid_idle_busy", {31'h0, b1.busy}, 32'h0);
    hold1 = 1'b1;
    b1.din = 16'hBEEF; b1.din_valid = 1'b1; exp1(16'hBEEF);
    tick();
    b1.din_valid = 1'b0;
    repeat (10) tick();
    check("post_rst_waits_ready", pulses1 - p, 32'd0);
    hold1 = 1'b0;
    wait_drain("drain_post_rst", 1000);

    // random words into both instances with random transmitter speed
    pushed = 0;
    n = 0;
    while (pushed < 40 && n < 20000) begin
      if (q1.size() <= 18 && q0.size() <= 15 && $urandom_range(0, 3) == 0) begin
        w = 16'($urandom);
        b1.din = w; b1.din_valid = 1'b1; exp1(w);
        b0.din = w; b0.din_valid = 1'b1; exp0(w);
        pushed++;
      end else begin
        b1.din_valid = 1'b0;
        b0.din_valid = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        lat1 = $urandom_range(1, 8);
        lat0 = $urandom_range(1, 8);
      end
      tick();
      n++;
    end
    b1.din_valid = 1'b0;
    b0.din_valid = 1'b0;
    check("rand_pushed", pushed, 32'd40);
    wait_drain("drain_rand", 5000);
    repeat (3) tick();
    check("rand_busy1", {31'h0, b1.busy}, 32'h0);
    check("rand_busy0", {31'h0, b0.busy}, 32'h0);
    check("final_ovf1", ovf1, 32'd1);
    check("final_ovf0", ovf0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit
  initial begin
    #1000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
